// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package : lcd_pkg
// Command encodings and sequencer state type shared by the LCD command path.
// Rev     : 1.0
// ============================================================================
package lcd_pkg;

    localparam int c_CMD_W = 4;

    typedef enum logic [3:0] {
        CMD_WRITE   = 4'h0,
        CMD_S_UP    = 4'h1,
        CMD_S_DOWN  = 4'h2,
        CMD_S_LEFT  = 4'h3,
        CMD_S_RIGHT = 4'h4,
        CMD_MAX     = 4'h5,
        CMD_MIN     = 4'h6,
        CMD_AVE     = 4'h7,
        CMD_C_ROT   = 4'h8,
        CMD_ROT     = 4'h9,
        CMD_M_X     = 4'hA,
        CMD_M_Y     = 4'hB
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_FINISHED   = 3'd5
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : lcd_cmd_fifo
// Circular command FIFO with registered full/empty/count flags.
// Rev    : 1.0
// ============================================================================
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = c_CMD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_rd;
    logic          w_wr;
    logic [AW:0]   w_wptr_nxt;
    logic [AW:0]   w_rptr_nxt;
    logic [AW:0]   w_cnt_nxt;

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_rd       = pop & ~empty;
    assign w_wr       = push & (~full | w_rd);
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd};
    assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;
    assign dout       = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            count  <= w_cnt_nxt;
            full   <= (w_cnt_nxt == c_FULL);
            empty  <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : lcd_cmd_sequencer
// Queues host commands and issues them to the LCD controller one per window.
// Rev    : 1.0
// ============================================================================
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    host_cmd,
    input  logic          host_push,
    output logic          host_full,
    output logic [AW:0]   host_count,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic          seq_idle,
    output logic [7:0]    issued_cnt,
    output logic          err_overflow,
    output logic          err_timeout
);

    localparam int              c_TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(ACK_TIMEOUT - 1);

    seq_state_e      r_state;
    logic [c_TW-1:0] r_tmo;
    logic            r_is_write;
    logic            w_empty;
    logic [3:0]      w_head;
    logic            w_pop;
    logic            w_drop;

    assign w_pop  = (r_state == ST_WAIT_READY) & ~busy & ~w_empty;
    assign w_drop = host_push & host_full & ~w_pop;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (c_CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_push),
        .pop   (w_pop),
        .din   (host_cmd),
        .dout  (w_head),
        .full  (host_full),
        .empty (w_empty),
        .count (host_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_tmo        <= '0;
            r_is_write   <= 1'b0;
            cmd          <= 4'h0;
            cmd_valid    <= 1'b0;
            seq_idle     <= 1'b1;
            issued_cnt   <= 8'd0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= 4'h0;
            if (w_drop) begin
                err_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_WAIT_READY;
                    seq_idle <= 1'b0;
                end
                ST_WAIT_READY: begin
                    if (w_pop) begin
                        r_state    <= ST_ISSUE;
                        cmd_valid  <= 1'b1;
                        cmd        <= w_head;
                        r_is_write <= (w_head == CMD_WRITE);
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_ACK;
                    r_tmo   <= '0;
                    if (issued_cnt != 8'hFF) begin
                        issued_cnt <= issued_cnt + 8'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    // A command that never gets acknowledged is dropped, not retried.
                    if (busy) begin
                        r_state <= r_is_write ? ST_WAIT_DONE : ST_WAIT_READY;
                    end else if (r_tmo == c_TMO_LAST) begin
                        err_timeout <= 1'b1;
                        r_state     <= ST_WAIT_READY;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (done) begin
                        r_state  <= ST_FINISHED;
                        seq_idle <= 1'b1;
                    end
                end
                ST_FINISHED: begin
                    r_state <= ST_FINISHED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_cmd_sequencer
// Directed + randomized bench with a controller model and command-order model.
// Rev    : 1.0
// ============================================================================
module tb_lcd_cmd_sequencer;

    localparam int DEPTH       = 16;
    localparam int AW          = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int BUSY_HOLD   = 2;
    localparam int SPACING     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  host_cmd = 4'h0;
    logic        host_push = 1'b0;
    logic        host_full;
    logic [AW:0] host_count;
    logic        busy;
    logic        done;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        seq_idle;
    logic [7:0]  issued_cnt;
    logic        err_overflow;
    logic        err_timeout;

    logic        man_busy = 1'b1;
    logic        auto_ctl = 1'b0;
    logic        ctl_busy;
    logic        ctl_done;
    logic        ign_en = 1'b0;
    logic [3:0]  ign_val = 4'h0;
    int          done_delay = 4;
    int          done_cyc = -1;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulse_cyc[$];
    logic [3:0]  pulse_cmd[$];
    int          to_rise_cyc = -1;
    logic        prev_to = 1'b0;
    int          idle_cyc = -1;

    logic [3:0]  mdl_q[$];
    logic        mdl_ovf = 1'b0;

    assign busy = auto_ctl ? ctl_busy : man_busy;
    assign done = ctl_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_push    (host_push),
        .host_full    (host_full),
        .host_count   (host_count),
        .busy         (busy),
        .done         (done),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .seq_idle     (seq_idle),
        .issued_cnt   (issued_cnt),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_push(input logic [3:0] c);
        if (mdl_q.size() < DEPTH) mdl_q.push_back(c);
        else mdl_ovf = 1'b1;
    endfunction

    task automatic push(input logic [3:0] c);
        host_cmd  = c;
        host_push = 1'b1;
        mdl_push(c);
        tick();
        host_push = 1'b0;
        host_cmd  = 4'h0;
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_idle"}, seq_idle, 1);
        check({tag, "_issued"}, issued_cnt, 0);
        check({tag, "_ovf"}, err_overflow, 0);
        check({tag, "_to"}, err_timeout, 0);
        check({tag, "_full"}, host_full, 0);
        check({tag, "_count"}, host_count, 0);
    endtask

    task automatic do_reset(input string tag);
        auto_ctl  = 1'b0;
        man_busy  = 1'b1;
        host_push = 1'b0;
        ign_en    = 1'b0;
        reset     = 1'b0;
        repeat (3) tick();
        chk_reset_outs(tag);
        pulse_cyc.delete();
        pulse_cmd.delete();
        mdl_q.delete();
        mdl_ovf     = 1'b0;
        to_rise_cyc = -1;
        done_cyc    = -1;
        reset       = 1'b1;
        tick();
    endtask

    task automatic wait_pulses(input string tag, input int n, input int lim);
        while (pulse_cmd.size() < n && lim > 0) begin
            @(negedge clk);
            lim--;
        end
        check({tag, "_npulses"}, pulse_cmd.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        while (!seq_idle && lim > 0) begin
            @(negedge clk);
            lim--;
        end
        idle_cyc = cyc;
        check({tag, "_idle"}, seq_idle, 1);
    endtask

    // Expected issue order: accepted pushes in order, stopping after the first WRITE.
    task automatic chk_issues(input string tag);
        logic [3:0] exp_l[$];
        foreach (mdl_q[i]) begin
            exp_l.push_back(mdl_q[i]);
            if (mdl_q[i] == 4'h0) break;
        end
        check({tag, "_nissue"}, pulse_cmd.size(), exp_l.size());
        foreach (exp_l[i])
            if (i < pulse_cmd.size())
                check($sformatf("%s_cmd%0d", tag, i), pulse_cmd[i], exp_l[i]);
    endtask

    task automatic chk_spacing(input string tag, input int from, input int upto);
        for (int i = from + 1; i <= upto; i++)
            if (i < pulse_cyc.size())
                check($sformatf("%s_gap%0d", tag, i), pulse_cyc[i] - pulse_cyc[i-1], SPACING);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                if (cmd_valid) begin
                    pulse_cyc.push_back(cyc);
                    pulse_cmd.push_back(cmd);
                end else begin
                    check("cmd_zero_when_invalid", cmd, 0);
                end
                if (err_timeout && !prev_to) to_rise_cyc = cyc;
            end
            prev_to = err_timeout;
        end
    end

    initial begin : ctl_model
        logic [3:0] c;
        ctl_busy = 1'b0;
        ctl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ctl && reset && cmd_valid && !(ign_en && cmd == ign_val)) begin
                c = cmd;
                @(posedge clk);
                #1 ctl_busy = 1'b1;
                if (c == 4'h0) begin
                    repeat (done_delay) @(posedge clk);
                    #1 ctl_done = 1'b1;
                    done_cyc = cyc;
                    @(posedge clk);
                    #1 ctl_done = 1'b0;
                    ctl_busy = 1'b0;
                end else begin
                    repeat (BUSY_HOLD) @(posedge clk);
                    #1 ctl_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int b, n, p;
        logic [3:0] c;

        // Held off by busy, then 5, 8, WRITE issue in order and finish on done.
        do_reset("t1_rst");
        push(4'h5);
        push(4'h8);
        push(4'h0);
        repeat (67) tick();
        check("t1_no_issue", pulse_cmd.size(), 0);
        check("t1_count", host_count, 3);
        check("t1_not_idle", seq_idle, 0);
        done_delay = 6;
        auto_ctl = 1'b1;
        b = cyc;
        wait_pulses("t1", 3, 40);
        check("t1_first_latency", pulse_cyc[0], b + 1);
        chk_issues("t1");
        chk_spacing("t1", 0, 2);
        check("t1_wait_done_not_idle", seq_idle, 0);
        wait_idle("t1", 100);
        check("t1_finish_after_done", idle_cyc, done_cyc + 1);
        check("t1_issued", issued_cnt, 3);
        repeat (4) tick();

        // Preloaded 1..4 at 4-cycle spacing, then a random burst ending in WRITE.
        do_reset("t2_rst");
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        done_delay = 4;
        auto_ctl = 1'b1;
        wait_pulses("t2a", 4, 40);
        repeat (3) tick();
        check("t2_issued4", issued_cnt, 4);
        check("t2_ready_not_idle", seq_idle, 0);
        n = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) begin
            c = 4'($urandom_range(1, 15));
            push(c);
        end
        push(4'h0);
        wait_pulses("t2b", n + 5, 8 * (n + 1) + 40);
        chk_issues("t2");
        chk_spacing("t2a", 0, 3);
        chk_spacing("t2b", 4, n + 4);
        wait_idle("t2", 60);
        check("t2_issued", issued_cnt, n + 5);
        repeat (4) tick();

        // Overflow: 17 pushes into 16 entries while the controller is busy.
        do_reset("t3_rst");
        for (int i = 0; i < 17; i++) begin
            c = 4'($urandom_range(1, 15));
            push(c);
            if (i == 14) check("t3_not_full15", host_full, 0);
            if (i == 15) begin
                check("t3_full16", host_full, 1);
                check("t3_no_ovf16", err_overflow, 0);
                check("t3_count16", host_count, 16);
            end
        end
        check("t3_ovf", err_overflow, mdl_ovf);
        check("t3_count", host_count, 16);
        check("t3_full", host_full, 1);
        auto_ctl = 1'b1;
        wait_pulses("t3", 16, 16 * SPACING + 40);
        repeat (4) tick();
        chk_issues("t3");
        chk_spacing("t3", 0, 15);
        check("t3_issued", issued_cnt, 16);
        check("t3_drained", host_count, 0);
        check("t3_unfull", host_full, 0);
        repeat (4) tick();

        // Ack timeout on cmd 7; the following command still issues.
        do_reset("t4_rst");
        push(4'h3); push(4'h7); push(4'h9);
        ign_en = 1'b1;
        ign_val = 4'h7;
        auto_ctl = 1'b1;
        wait_pulses("t4", 3, 80);
        chk_issues("t4");
        chk_spacing("t4", 0, 1);
        check("t4_to_latency", to_rise_cyc, pulse_cyc[1] + 1 + ACK_TIMEOUT);
        check("t4_next_issue", pulse_cyc[2], to_rise_cyc + 1);
        repeat (4) tick();
        check("t4_to_sticky", err_timeout, 1);
        check("t4_issued", issued_cnt, 3);
        repeat (4) tick();

        // WRITE with a long write-back; later pushes never issue.
        do_reset("t5_rst");
        push(4'h0);
        done_delay = 70;
        auto_ctl = 1'b1;
        wait_pulses("t5", 1, 20);
        repeat (30) tick();
        check("t5_waiting_not_idle", seq_idle, 0);
        push(4'h9);
        wait_idle("t5", 100);
        check("t5_finish_after_done", idle_cyc, done_cyc + 1);
        repeat (20) tick();
        chk_issues("t5");
        check("t5_count", host_count, 1);
        check("t5_idle", seq_idle, 1);
        check("t5_issued", issued_cnt, 1);

        // Asynchronous reset mid WAIT_ACK with five queued entries.
        do_reset("t6_rst");
        c = 4'($urandom_range(1, 15));
        push(c);
        for (int i = 0; i < 5; i++) push(4'($urandom_range(1, 15)));
        ign_en = 1'b1;
        ign_val = c;
        auto_ctl = 1'b1;
        wait_pulses("t6", 1, 20);
        p = pulse_cyc[0];
        tick();
        check("t6_pre_count", host_count, 5);
        check("t6_pre_issued", issued_cnt, 1);
        check("t6_pre_cmd", pulse_cmd[0], c);
        #2 reset = 1'b0;
        #1;
        chk_reset_outs("t6_async");
        check("t6_still_in_window", cyc - p <= ACK_TIMEOUT, 1);
        auto_ctl = 1'b0;
        repeat (3) tick();
        chk_reset_outs("t6_held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Upstream command feeder for the LCD image controller.
- A host pushes 4-bit LCD commands into an internal FIFO at any rate.
- The block pops the FIFO and issues each command to the controller over its cmd/cmd_valid/busy handshake, one command per controller-ready window.
- After issuing WRITE (4'h0) it waits for the controller's done and then stops.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 2..64).
- AW, 4, log2(DEPTH).
- ACK_TIMEOUT, 8, max cycles to wait for busy to rise after a cmd_valid pulse.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_cmd  in  4  command to enqueue.
- host_push  in  1  enqueue strobe.
- host_full  out  1  FIFO full.
- host_count  out  AW+1  current FIFO occupancy.
- busy  in  1  controller busy (1 = not accepting commands).
- done  in  1  controller finished image write-back.
- cmd  out  4  command to controller; 4'h0 when cmd_valid=0.
- cmd_valid  out  1  single-cycle command strobe.
- seq_idle  out  1  1 in IDLE or FINISHED.
- issued_cnt  out  8  commands issued since reset; saturates at 255.
- err_overflow  out  1  sticky: a push was dropped.
- err_timeout  out  1  sticky: busy failed to rise after an issue.

Behaviour:
- Reset values: all outputs 0 except seq_idle=1; FIFO empty; state IDLE.
  - Asserting reset mid-operation aborts immediately and discards FIFO contents.
- All outputs are registered.
- FIFO:
  - Circular, with read/write pointers of AW+1 bits.
  - A push is accepted when host_full=0, or when a pop occurs in the same cycle; both happen in that cycle.
  - A push while full with no pop is dropped and sets err_overflow.
  - Pushes are still accepted in FINISHED; nothing further is issued.
- States: IDLE, WAIT_READY, ISSUE, WAIT_ACK, WAIT_DONE, FINISHED.
- IDLE: go to WAIT_READY on the first cycle after reset release.
- WAIT_READY: if busy=0 and the FIFO is non-empty, pop the head and go to ISSUE. Otherwise stay.
  - Controller busy is 1 out of reset until its image load completes, so no command issues before then.
- ISSUE: cmd_valid=1 and cmd=popped value for exactly one cycle. Then go to WAIT_ACK, with timeout counter cleared; issued_cnt increments (saturating).
- WAIT_ACK:
  - On busy=1, go to WAIT_DONE if the issued cmd was 4'h0, else to WAIT_READY.
  - Expected latency: busy=1 is sampled on the first WAIT_ACK cycle.
  - If ACK_TIMEOUT cycles pass without busy=1, set err_timeout and go to WAIT_READY; the command is not retried.
- WAIT_DONE: on done=1, go to FINISHED. No time limit (write-back is 64+ cycles).
- FINISHED: terminal until reset; cmd_valid=0, seq_idle=1.
- Back-to-back issue: after a non-WRITE command, the next cmd_valid may assert at the earliest 1 cycle after busy returns to 0. The minimum spacing between cmd_valid pulses is 4 cycles.
- Pop and push on an empty FIFO in the same cycle: not possible, since a pop requires non-empty. The pushed entry becomes visible the next cycle.
- done=1 outside WAIT_DONE is ignored.
- Command values 4'hC–4'hF are passed through unmodified; the controller treats them as no-ops.

Decomposition:
- Shared package lcd_pkg:
  - Command encodings: WRITE=0, S_UP=1, S_DOWN=2, S_LEFT=3, S_RIGHT=4, MAX=5, MIN=6, AVE=7, C_ROT=8, ROT=9, M_X=10, M_Y=11.
  - Sequencer state enum.
- One sub-module: lcd_cmd_fifo.
  - Parameterised DEPTH/AW.
  - Ports: push, pop, din, dout, full, empty, count.
  - The top level holds the FSM, timeout counter and status.

Test Plan:
- Reset, then hold busy=1 for 70 cycles while pushing 3 commands (5, 8, 0) -> no cmd_valid; host_count=3. After busy drops: cmd_valid pulses with cmd=5, 8, 0 in order, issued_cnt=3. FINISHED is reached only after done=1; seq_idle=1.
- Controller model with a 1-cycle busy response, FIFO preloaded with 1,2,3,4 -> cmd_valid pulses spaced exactly 4 cycles apart, each one cycle wide; cmd=0 between pulses.
- Push 17 commands into a DEPTH=16 FIFO with busy=1 -> host_full=1 after the 16th push; the 17th is dropped; err_overflow=1; host_count=16.
- Model never raises busy after cmd=7 -> err_timeout=1 exactly 8 cycles after WAIT_ACK entry. The FSM returns to WAIT_READY, and the next queued command issues normally.
- Issue WRITE with done delayed 70 cycles, then push 9 -> no cmd_valid while waiting or after FINISHED; host_count=1.
- Assert reset while in WAIT_ACK with 5 queued entries -> all outputs return to reset values immediately; host_count=0; issued_cnt=0.
